// File: rtl/counter_job_scheduler_pkg.sv
// Shared definitions for the counter job scheduler and its counter engine.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package counter_job_scheduler_pkg;

    // Width of the engine's count value and of each requester's job slice.
    localparam int CNT_W = 8;

    // Counter engine states.
    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_RUN  = 2'd1,
        E_DONE = 2'd2
    } eng_state_t;

    // Scheduler states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/counter_job_scheduler_fsm_counter.sv
// Counter engine: on a run pulse counts 0..i_num_cnt, then flags done for one cycle.
// Latency: run at T, RUN from T+1 for num+1 cycles, DONE at T+2+num, idle again after.
// Backpressure: none; i_run is ignored unless the engine is idle.
module fsm_counter
    import counter_job_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_num_cnt,
    output logic             o_done,
    output logic             o_idle,
    output logic             o_running
);

    eng_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Engine sequencing: start on run, count up to the requested value, report done once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= E_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                E_IDLE: begin
                    if (i_run) begin
                        state <= E_RUN;
                        cnt   <= '0;
                    end
                end
                E_RUN: begin
                    if (cnt == i_num_cnt) begin
                        state <= E_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                E_DONE: begin
                    state <= E_IDLE;
                end
                default: begin
                    state <= E_IDLE;
                end
            endcase
        end
    end

    assign o_done    = (state == E_DONE);
    assign o_idle    = (state == E_IDLE);
    assign o_running = (state == E_RUN);

endmodule

// File: rtl/counter_job_scheduler.sv
// Round-robin scheduler sharing one counter engine between N_REQ requesters.
// Latency: grant at T (combinational), done pulse at T+4+num, next grant at T+5+num earliest.
// Backpressure: requests are only sampled in IDLE; requesters hold i_req until granted.
module counter_job_scheduler
    import counter_job_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [CNT_W*N_REQ-1:0] i_num,
    input  logic [N_REQ-1:0]       i_mask,
    output logic [N_REQ-1:0]       o_grant,
    output logic                   o_busy,
    output logic [ID_W-1:0]        o_busy_id,
    output logic [N_REQ-1:0]       o_done
);

    sched_state_t     state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] num_q;

    logic [N_REQ-1:0] elig;
    logic [ID_W:0]    pick;
    logic             pick_vld;
    logic [ID_W-1:0]  pick_idx;
    logic [CNT_W-1:0] pick_num;
    logic             eng_run;
    logic             eng_done;

    // Rotate the eligible set so the search starts at base, take the lowest
    // set bit, then map it back to a requester index. MSB of result = found.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vec,
                                              input logic [ID_W-1:0]  base);
        logic [N_REQ-1:0] rot;
        logic [ID_W-1:0]  src;
        logic [ID_W:0]    res;
        rot = '0;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            src    = ID_W'((i + int'(base)) % N_REQ);
            rot[i] = vec[src];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                res = {1'b1, ID_W'((i + int'(base)) % N_REQ)};
            end
        end
        return res;
    endfunction

    assign elig     = i_req & ~i_mask;
    assign pick     = rr_pick(elig, ptr);
    assign pick_vld = pick[ID_W] && (state == S_IDLE);
    assign pick_idx = pick[ID_W-1:0];

    // Select the winner's job count from the flattened count bus.
    always_comb begin
        pick_num = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == ID_W'(k)) begin
                pick_num = i_num[CNT_W*k +: CNT_W];
            end
        end
    end

    // Job lifecycle: accept in IDLE, launch the engine, wait for it, retire and advance the pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            ptr   <= '0;
            id_q  <= '0;
            num_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        num_q <= pick_num;
                        id_q  <= pick_idx;
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Engine done is only honoured here; stray pulses elsewhere are ignored.
                    if (eng_done) begin
                        state <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    ptr   <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: grant straight from arbitration, everything else from registered state.
    always_comb begin
        o_grant   = '0;
        o_done    = '0;
        o_busy    = (state != S_IDLE);
        o_busy_id = o_busy ? id_q : '0;
        // Gate with reset so that a request held during reset cannot show a grant.
        if (pick_vld && reset) begin
            o_grant[pick_idx] = 1'b1;
        end
        if (state == S_RETIRE) begin
            o_done[id_q] = 1'b1;
        end
    end

    assign eng_run = (state == S_LAUNCH);

    fsm_counter u_engine (
        .clk       (clk),
        .reset     (reset),
        .i_run     (eng_run),
        .i_num_cnt (num_q),
        .o_done    (eng_done),
        .o_idle    (),
        .o_running ()
    );

endmodule
